// File: rtl/parking_sensor_gen.sv
// Transmit side of the parking-gate sensor protocol: drives the (a,b) photo-sensor
// pair through enter/exit crossing sequences and tracks lot occupancy.
module parking_sensor_gen #(
    parameter int CAPACITY = 8,
    parameter int HOLD_W   = 4,
    parameter int GAP      = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_dir,
    input  logic [HOLD_W-1:0]             i_cmd_hold,
    output logic                          o_a,
    output logic                          o_b,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_rej,
    output logic [$clog2(CAPACITY+1)-1:0] o_count
);

    localparam int CNT_W = $clog2(CAPACITY + 1);
    localparam int GAP_W = ($clog2(GAP) > 0) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_P2,
        S_P3,
        S_GAP
    } state_t;

    state_t             r_state;
    logic               r_dir;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  r_phCnt;
    logic [GAP_W-1:0]   r_gapCnt;
    logic [CNT_W-1:0]   r_count;
    logic               r_a;
    logic               r_b;
    logic               r_done;
    logic               r_rej;

    logic               w_ready;
    logic               w_accept;
    logic               w_reject;

    assign w_ready  = (r_state == S_IDLE);
    assign w_accept = i_cmd_valid & w_ready;
    assign w_reject = i_cmd_dir ? (r_count == '0)
                                : (r_count == CNT_W'(CAPACITY));

    // Outer sensor leads on entry, inner sensor leads on exit; only one bit flips per edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_dir    <= 1'b0;
            r_hold   <= '0;
            r_phCnt  <= '0;
            r_gapCnt <= '0;
            r_count  <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_done   <= 1'b0;
            r_rej    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_rej  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_reject) begin
                            r_rej <= 1'b1;
                        end else begin
                            r_dir   <= i_cmd_dir;
                            r_hold  <= i_cmd_hold;
                            r_phCnt <= i_cmd_hold;
                            r_state <= S_P1;
                            r_a     <= ~i_cmd_dir;
                            r_b     <= i_cmd_dir;
                        end
                    end
                end
                S_P1: begin
                    if (r_phCnt == '0) begin
                        r_state <= S_P2;
                        r_phCnt <= r_hold;
                        r_a     <= 1'b1;
                        r_b     <= 1'b1;
                    end else begin
                        r_phCnt <= r_phCnt - HOLD_W'(1);
                    end
                end
                S_P2: begin
                    if (r_phCnt == '0) begin
                        r_state <= S_P3;
                        r_phCnt <= r_hold;
                        r_a     <= r_dir;
                        r_b     <= ~r_dir;
                    end else begin
                        r_phCnt <= r_phCnt - HOLD_W'(1);
                    end
                end
                S_P3: begin
                    if (r_phCnt == '0) begin
                        r_state  <= S_GAP;
                        r_gapCnt <= GAP_W'(GAP - 1);
                        r_a      <= 1'b0;
                        r_b      <= 1'b0;
                        r_done   <= 1'b1;
                        r_count  <= r_dir ? (r_count - CNT_W'(1)) : (r_count + CNT_W'(1));
                    end else begin
                        r_phCnt <= r_phCnt - HOLD_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_gapCnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_a     <= 1'b0;
                    r_b     <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_ready = w_ready;
    assign o_busy      = ~w_ready;
    assign o_a         = r_a;
    assign o_b         = r_b;
    assign o_done      = r_done;
    assign o_rej       = r_rej;
    assign o_count     = r_count;

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Scoreboard bench for parking_sensor_gen: the driver queues expected crossings and
// rejects at accept time, a monitor checks sensor phases, done/rej pulses and counts.
module tb_parking_sensor_gen;

    localparam int CAPACITY = 8;
    localparam int HOLD_W   = 4;
    localparam int GAP      = 2;
    localparam int CNT_W    = 4;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic              cmdValid = 1'b0;
    logic              cmdDir = 1'b0;
    logic [HOLD_W-1:0] cmdHold = '0;
    logic              cmdReady;
    logic              sensA;
    logic              sensB;
    logic              busy;
    logic              done;
    logic              rej;
    logic [CNT_W-1:0]  count;

    parking_sensor_gen #(
        .CAPACITY (CAPACITY),
        .HOLD_W   (HOLD_W),
        .GAP      (GAP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_cmd_valid (cmdValid),
        .o_cmd_ready (cmdReady),
        .i_cmd_dir   (cmdDir),
        .i_cmd_hold  (cmdHold),
        .o_a         (sensA),
        .o_b         (sensB),
        .o_busy      (busy),
        .o_done      (done),
        .o_rej       (rej),
        .o_count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit isRej;
        bit dir;
        int hold;
        int countAfter;
    } exp_t;

    exp_t expQ[$];
    int   numCompared = 0;
    int   numMismatch = 0;
    int   tbCount = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        numCompared++;
        if (actual != expected) begin
            numMismatch++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [1:0] phasePattern(input bit dir, input int phase);
        if (phase == 0) return dir ? 2'b01 : 2'b10;
        if (phase == 1) return 2'b11;
        return dir ? 2'b10 : 2'b01;
    endfunction

    // Offer one command; the expected outcome is decided from the bench's own count model.
    task automatic applyStimulus(input bit dir, input int hold, input bit keepValid);
        int   waitCycles;
        exp_t e;
        waitCycles = 0;
        @(negedge clk);
        cmdValid = 1'b1;
        cmdDir   = dir;
        cmdHold  = HOLD_W'(hold);
        while (!cmdReady && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!cmdReady) begin
            checkOutput("acceptTimeout", 0, 1);
            cmdValid = 1'b0;
            return;
        end
        @(posedge clk);
        e.dir  = dir;
        e.hold = hold;
        if ((dir && tbCount == 0) || (!dir && tbCount == CAPACITY)) begin
            e.isRej      = 1'b1;
            e.countAfter = tbCount;
        end else begin
            e.isRej      = 1'b0;
            tbCount      = dir ? tbCount - 1 : tbCount + 1;
            e.countAfter = tbCount;
        end
        expQ.push_back(e);
        #1;
        if (!keepValid) cmdValid = 1'b0;
    endtask

    task automatic waitIdle();
        int cycles;
        cycles = 0;
        @(negedge clk);
        while ((expQ.size() != 0 || busy) && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("idleReached", (expQ.size() == 0 && !busy) ? 1 : 0, 1);
    endtask

    bit   active = 1'b0;
    bit   havePrev = 1'b0;
    exp_t cur;
    int   phase = 0;
    int   run = 0;
    int   busyRun = 0;
    int   expBusy = 0;
    int   zeroRun = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstN) begin
                active   = 1'b0;
                havePrev = 1'b0;
                busyRun  = 0;
                continue;
            end
            if (busy) begin
                busyRun++;
            end else if (busyRun > 0) begin
                checkOutput("busyLen", busyRun, expBusy);
                busyRun = 0;
            end
            if (rej) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedRej", 1, 0);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("rejExpected", cur.isRej, 1);
                    checkOutput("rejCount", count, cur.countAfter);
                    checkOutput("rejAb", {sensA, sensB}, 0);
                    checkOutput("rejReady", cmdReady, 1);
                end
            end
            if (!active && {sensA, sensB} != 2'b00) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedCar", 1, 0);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("carNotRej", cur.isRej, 0);
                    active  = 1'b1;
                    phase   = 0;
                    run     = 0;
                    expBusy = 3 * (cur.hold + 1) + GAP;
                    if (havePrev) checkOutput("gapAtLeast", (zeroRun >= GAP) ? 1 : 0, 1);
                end
            end
            if (active) begin
                if (phase < 3) begin
                    checkOutput("abPhase", {sensA, sensB}, phasePattern(cur.dir, phase));
                    checkOutput("doneLow", done, 0);
                    checkOutput("readyLow", cmdReady, 0);
                    run++;
                    if (run == cur.hold + 1) begin
                        phase++;
                        run = 0;
                    end
                end else begin
                    checkOutput("doneHigh", done, 1);
                    checkOutput("rejLowAtDone", rej, 0);
                    checkOutput("doneAb", {sensA, sensB}, 0);
                    checkOutput("doneCount", count, cur.countAfter);
                    active   = 1'b0;
                    havePrev = 1'b1;
                    zeroRun  = 1;
                end
            end else begin
                if (done) checkOutput("unexpectedDone", 1, 0);
                if ({sensA, sensB} == 2'b00) zeroRun++;
            end
        end
    end

    initial begin
        int waitCycles;
        #17 rstN = 1'b1;
        @(negedge clk);
        checkOutput("rstReady", cmdReady, 1);
        checkOutput("rstAb", {sensA, sensB}, 0);
        checkOutput("rstCount", count, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstRej", rej, 0);

        applyStimulus(1'b0, 0, 1'b0);
        waitIdle();
        checkOutput("enterCount", count, 1);

        applyStimulus(1'b1, 2, 1'b0);
        waitIdle();
        checkOutput("exitCount", count, 0);

        applyStimulus(1'b1, 1, 1'b0);
        waitIdle();
        checkOutput("emptyRejCount", count, 0);

        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        waitIdle();
        checkOutput("fullCount", count, CAPACITY);

        applyStimulus(1'b1, 3, 1'b0);
        waitCycles = 0;
        @(negedge clk);
        while ({sensA, sensB} != 2'b11 && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("reachedP2", {sensA, sensB}, 3);
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midRstAb", {sensA, sensB}, 0);
        checkOutput("midRstCount", count, 0);
        checkOutput("midRstDone", done, 0);
        expQ.delete();
        tbCount = 0;
        repeat (2) @(posedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        checkOutput("postRstReady", cmdReady, 1);
        checkOutput("postRstBusy", busy, 0);

        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b0, 1, 1'b1);
        applyStimulus(1'b0, 0, 1'b0);
        waitIdle();
        checkOutput("b2bCount", count, 3);

        applyStimulus(1'b1, 1, 1'b0);
        applyStimulus(1'b0, 5, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("queueEmpty", expQ.size(), 0);
        checkOutput("finalCount", count, tbCount);
        checkOutput("finalCountZero", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatch);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
